// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG bit collector.
// The optional Von Neumann debiaser is selected with TRNG_VON_NEUMANN_EN.
package trng_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        COLLECT = 2'd2,
        FAIL    = 2'd3
    } trng_state_e;

    localparam int SBOX_W        = 5;
    localparam int SYNC_STAGES   = 2;
    localparam int WARMUP_CYCLES = 2;

endpackage

// File: rtl/trng_sync2.sv
// Two-flop synchroniser bringing the asynchronous ring-oscillator bit into clk.
module trng_sync2
    import trng_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/trng_bit_collector.sv
// Decimates the synchronised raw bit, packs 5-bit words for the S-box stage and runs
// a repetition-count health test. Define TRNG_VON_NEUMANN_EN to debias sample pairs.
module trng_bit_collector
    import trng_pkg::*;
#(
    parameter int SAMPLE_DIV = 4,
    parameter int REP_LIMIT  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              raw_bit,
    output logic [SBOX_W-1:0] sbox_in,
    output logic              activate_sbox,
    output logic              health_fail,
    output logic              busy
);

    localparam logic [7:0] DIV_LAST  = 8'(SAMPLE_DIV - 1);
    localparam logic [7:0] REP_MAX   = 8'(REP_LIMIT);
    localparam logic [2:0] LAST_BIT  = 3'(SBOX_W - 1);
    localparam logic [1:0] WARM_LAST = 2'(WARMUP_CYCLES - 1);

    logic sync_bit;

    trng_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (raw_bit),
        .q     (sync_bit)
    );

    trng_state_e       state_q, state_d;
    logic [1:0]        warm_cnt_q, warm_cnt_d;
    logic [7:0]        div_cnt_q, div_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [SBOX_W-2:0] shift_q, shift_d;
    logic [7:0]        rep_cnt_q, rep_cnt_d;
    logic              prev_q, prev_d;
    logic [SBOX_W-1:0] sbox_q, sbox_d;
    logic              act_q, act_d;
    logic              fail_q, fail_d;
    logic              busy_q, busy_d;
`ifdef TRNG_VON_NEUMANN_EN
    logic              pair_q, pair_d;
    logic              phase_q, phase_d;
`endif

    logic       strobe;
    logic       same;
    logic [7:0] rep_next;
    logic       accept;
    logic       acc_bit;

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rep_cnt_d  = rep_cnt_q;
        prev_d     = prev_q;
        sbox_d     = sbox_q;
        act_d      = 1'b0;
        fail_d     = fail_q;
        strobe     = 1'b0;
        same       = 1'b0;
        rep_next   = rep_cnt_q;
        accept     = 1'b0;
        acc_bit    = sync_bit;
`ifdef TRNG_VON_NEUMANN_EN
        pair_d     = pair_q;
        phase_d    = phase_q;
`endif

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d    = WARMUP;
                    warm_cnt_d = '0;
                end
            end
            WARMUP: begin
                if (warm_cnt_q == WARM_LAST) begin
                    state_d   = COLLECT;
                    div_cnt_d = '0;
                end else begin
                    warm_cnt_d = warm_cnt_q + 2'd1;
                end
            end
            COLLECT: begin
                strobe    = (div_cnt_q == DIV_LAST);
                div_cnt_d = strobe ? 8'd0 : div_cnt_q + 8'd1;
                if (strobe) begin
                    // rep_cnt of 0 means no previous sample since IDLE.
                    same      = (rep_cnt_q != 8'd0) && (sync_bit == prev_q);
                    rep_next  = !same ? 8'd1
                              : ((rep_cnt_q == 8'hFF) ? rep_cnt_q : rep_cnt_q + 8'd1);
                    rep_cnt_d = rep_next;
                    prev_d    = sync_bit;
`ifdef TRNG_VON_NEUMANN_EN
                    if (!phase_q) begin
                        pair_d  = sync_bit;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        accept  = (pair_q != sync_bit);
                        acc_bit = pair_q;
                    end
`else
                    accept = 1'b1;
`endif
                    if (rep_next == REP_MAX) begin
                        state_d   = FAIL;
                        fail_d    = 1'b1;
                        bit_cnt_d = '0;
                        shift_d   = '0;
`ifdef TRNG_VON_NEUMANN_EN
                        pair_d    = 1'b0;
                        phase_d   = 1'b0;
`endif
                    end else if (accept) begin
                        shift_d = {shift_q[SBOX_W-3:0], acc_bit};
                        if (bit_cnt_q == LAST_BIT) begin
                            sbox_d    = {shift_q, acc_bit};
                            act_d     = 1'b1;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
            end
            FAIL: begin
            end
            default: state_d = IDLE;
        endcase

        // Dropping enable overrides everything, including a word completing this edge.
        if (!enable) begin
            state_d    = IDLE;
            warm_cnt_d = '0;
            div_cnt_d  = '0;
            bit_cnt_d  = '0;
            shift_d    = '0;
            rep_cnt_d  = '0;
            prev_d     = 1'b0;
            sbox_d     = sbox_q;
            act_d      = 1'b0;
            fail_d     = 1'b0;
`ifdef TRNG_VON_NEUMANN_EN
            pair_d     = 1'b0;
            phase_d    = 1'b0;
`endif
        end

        busy_d = (state_d == WARMUP) || (state_d == COLLECT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            warm_cnt_q <= '0;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rep_cnt_q  <= '0;
            prev_q     <= 1'b0;
            sbox_q     <= '0;
            act_q      <= 1'b0;
            fail_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef TRNG_VON_NEUMANN_EN
            pair_q     <= 1'b0;
            phase_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rep_cnt_q  <= rep_cnt_d;
            prev_q     <= prev_d;
            sbox_q     <= sbox_d;
            act_q      <= act_d;
            fail_q     <= fail_d;
            busy_q     <= busy_d;
`ifdef TRNG_VON_NEUMANN_EN
            pair_q     <= pair_d;
            phase_q    <= phase_d;
`endif
        end
    end

    assign sbox_in       = sbox_q;
    assign activate_sbox = act_q;
    assign health_fail   = fail_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_trng_bit_collector.sv
// Bench for trng_bit_collector: behavioural model compared every cycle, directed
// literal scenarios, then randomized raw/enable/reset traffic.
module tb_trng_bit_collector;

    localparam int D   = 4;
    localparam int REP = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       raw_bit = 1'b0;
    logic [4:0] sbox_in;
    logic       activate_sbox;
    logic       health_fail;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    trng_bit_collector #(.SAMPLE_DIV(D), .REP_LIMIT(REP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .raw_bit       (raw_bit),
        .sbox_in       (sbox_in),
        .activate_sbox (activate_sbox),
        .health_fail   (health_fail),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: run = consecutive enabled edges; collection begins after
    // edge 3 of a run, so strobes fall on run values 3+D, 3+2D, ...
    int         run = 0;
    bit         failed = 1'b0;
    bit         exp_act = 1'b0;
    logic [4:0] exp_sbox = '0;
    bit         exp_busy = 1'b0;
    int         same_len = 0;
    logic       last_smp = 1'b0;
    logic [1:0] dly = '0;
    logic       smp;
    bit         acc_q[$];
`ifdef TRNG_VON_NEUMANN_EN
    bit         pair_have = 1'b0;
    logic       pair_first = 1'b0;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run = 0; failed = 1'b0; exp_act = 1'b0; exp_sbox = '0; exp_busy = 1'b0;
            same_len = 0; last_smp = 1'b0; dly = '0; acc_q.delete();
`ifdef TRNG_VON_NEUMANN_EN
            pair_have = 1'b0;
`endif
        end else begin
            smp = dly[1];
            dly = {dly[0], raw_bit};
            exp_act = 1'b0;
            if (!enable) begin
                run = 0; failed = 1'b0; same_len = 0; acc_q.delete();
`ifdef TRNG_VON_NEUMANN_EN
                pair_have = 1'b0;
`endif
            end else if (!failed) begin
                run++;
                if (run > 3 && (run - 3) % D == 0) begin
                    if (same_len > 0 && smp == last_smp) same_len++;
                    else same_len = 1;
                    last_smp = smp;
                    if (same_len == REP) begin
                        failed = 1'b1;
                        acc_q.delete();
`ifdef TRNG_VON_NEUMANN_EN
                        pair_have = 1'b0;
`endif
                    end else begin
`ifdef TRNG_VON_NEUMANN_EN
                        if (!pair_have) begin
                            pair_first = smp;
                            pair_have = 1'b1;
                        end else begin
                            pair_have = 1'b0;
                            if (pair_first != smp) acc_q.push_back(pair_first);
                        end
`else
                        acc_q.push_back(smp);
`endif
                        if (acc_q.size() == 5) begin
                            exp_sbox = {acc_q[0], acc_q[1], acc_q[2], acc_q[3], acc_q[4]};
                            exp_act = 1'b1;
                            acc_q.delete();
                        end
                    end
                end
            end
            exp_busy = (run >= 1) && !failed;
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_sbox_in", {3'b0, sbox_in}, {3'b0, exp_sbox});
            chk("model_activate", {7'b0, activate_sbox}, {7'b0, exp_act});
            chk("model_health_fail", {7'b0, health_fail}, {7'b0, failed});
            chk("model_busy", {7'b0, busy}, {7'b0, exp_busy});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Starts from IDLE: raises enable and holds bit i for sample window i (MSB first).
    // Returns just after the edge of the n-th strobe.
    task automatic feed(input logic [31:0] bits, input int n);
        raw_bit = bits[n-1];
        enable = 1'b1;
        tick(3 + D);
        for (int i = 1; i < n; i++) begin
            raw_bit = bits[n-1-i];
            tick(D);
        end
    endtask

    int   mode;
    logic stuck;

    initial begin
        rst_n = 1'b0; enable = 1'b0; raw_bit = 1'b0;
        tick(3);
        chk_en = 1'b1;
        chk("reset_sbox", {3'b0, sbox_in}, 8'h00);
        chk("reset_act", {7'b0, activate_sbox}, 8'h00);
        chk("reset_hf", {7'b0, health_fail}, 8'h00);
        chk("reset_busy", {7'b0, busy}, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            chk("idle_act", {7'b0, activate_sbox}, 8'h00);
            chk("idle_busy", {7'b0, busy}, 8'h00);
        end

`ifdef TRNG_VON_NEUMANN_EN
        feed(32'b01100011101001, 14);
        chk("vn_pulse", {7'b0, activate_sbox}, 8'h01);
        chk("vn_word", {3'b0, sbox_in}, 8'h0E);
`else
        feed(32'b10110, 5);
        chk("basic_pulse", {7'b0, activate_sbox}, 8'h01);
        chk("basic_word", {3'b0, sbox_in}, 8'h16);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("basic_stable", {3'b0, sbox_in}, 8'h16);
            chk("basic_single", {7'b0, activate_sbox}, 8'h00);
        end
        enable = 1'b0;
        tick(2);
        feed(32'b100, 3);
        enable = 1'b0;
        tick(2);
        feed(32'b01101, 5);
        chk("drop_pulse", {7'b0, activate_sbox}, 8'h01);
        chk("drop_word", {3'b0, sbox_in}, 8'h0D);
`endif

        enable = 1'b0;
        tick(2);
        raw_bit = 1'b1;
        enable = 1'b1;
        tick(3 + 15 * D);
`ifndef TRNG_VON_NEUMANN_EN
        chk("health_word15", {7'b0, activate_sbox}, 8'h01);
        chk("health_word15_val", {3'b0, sbox_in}, 8'h1F);
`endif
        tick(D - 1);
        chk("health_before", {7'b0, health_fail}, 8'h00);
        tick(1);
        chk("health_trip", {7'b0, health_fail}, 8'h01);
        chk("health_trip_busy", {7'b0, busy}, 8'h00);
        chk("health_trip_act", {7'b0, activate_sbox}, 8'h00);
        tick(20);
        chk("health_sticky", {7'b0, health_fail}, 8'h01);
        enable = 1'b0;
        tick(1);
        chk("health_clear", {7'b0, health_fail}, 8'h00);
        tick(1);

        raw_bit = 1'b0;
        enable = 1'b1;
        tick(3 + 2 * D);
        rst_n = 1'b0;
        #1;
        chk("areset_sbox", {3'b0, sbox_in}, 8'h00);
        chk("areset_busy", {7'b0, busy}, 8'h00);
        chk("areset_act", {7'b0, activate_sbox}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`ifdef TRNG_VON_NEUMANN_EN
        feed(32'b01100011101001, 14);
        chk("areset_vn_pulse", {7'b0, activate_sbox}, 8'h01);
        chk("areset_vn_word", {3'b0, sbox_in}, 8'h0E);
`else
        feed(32'b10110, 5);
        chk("areset_pulse", {7'b0, activate_sbox}, 8'h01);
        chk("areset_word", {3'b0, sbox_in}, 8'h16);
`endif

        for (int ep = 0; ep < 12; ep++) begin
            mode = $urandom_range(0, 2);
            stuck = 1'($urandom_range(0, 1));
            for (int c = 0; c < 300; c++) begin
                case (mode)
                    0: raw_bit = 1'($urandom_range(0, 1));
                    1: raw_bit = stuck;
                    default: if ($urandom_range(0, 7) == 0) raw_bit = ~raw_bit;
                endcase
                if ($urandom_range(0, 199) == 0) enable = 1'b0;
                else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
                rst_n = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
                tick(1);
            end
        end
        rst_n = 1'b1;
        enable = 1'b0;
        tick(4);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/trng_bit_collector.md
Name: trng_bit_collector

Overview:
- Upstream feeder of the TRNG's 5-bit Ascon S-box conditioning stage.
- Synchronises the asynchronous raw ring-oscillator bit and decimates it to one sample every SAMPLE_DIV clocks.
- Packs 5 samples into a word, presents it on sbox_in and issues a one-cycle activate_sbox pulse per completed word.
- Runs an online repetition-count health test that blocks output when the source sticks.

Parameters:
- SAMPLE_DIV, 4: clocks between raw-bit samples; legal range 1..255.
- REP_LIMIT, 16: consecutive identical samples that trip the health test; legal range 2..255.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- enable  input  1  collection enable, synchronous level
- raw_bit  input  1  raw entropy bit, asynchronous to clk
- sbox_in  output  5  last completed word; first-collected bit in [4], last in [0]
- activate_sbox  output  1  one-cycle pulse, same cycle sbox_in takes a new word
- health_fail  output  1  sticky repetition-test failure flag
- busy  output  1  high in WARMUP or COLLECT

Behaviour:
- Reset (rst_n low, async): state=IDLE; all counters, the shift register and the synchroniser flops are 0. sbox_in=0, activate_sbox=0, health_fail=0, busy=0.
- raw_bit passes through a 2-flop synchroniser (2-cycle latency). Only the synchronised bit is used.
- States:
  - IDLE -> WARMUP when enable=1.
  - WARMUP lasts exactly 2 clocks (flushes the synchroniser) -> COLLECT.
  - COLLECT -> FAIL on a health trip.
  - Any state -> IDLE on the next edge when enable=0.
- Entering IDLE clears div_cnt, bit_cnt, rep_cnt, the partial word and health_fail. sbox_in keeps the last completed word.
- COLLECT, decimation:
  - div_cnt counts 0..SAMPLE_DIV-1 and wraps.
  - A sample strobe occurs on the edge where div_cnt==SAMPLE_DIV-1; the synchronised bit is taken on that edge.
- Packing:
  - Each accepted bit shifts into the LSB of a 5-bit shift register; bit_cnt counts 0..4.
  - On the 5th accepted bit, on the same edge: sbox_in <= {shift[3:0], new_bit}, activate_sbox <= 1, bit_cnt <= 0.
  - activate_sbox is high for exactly one cycle.
  - First word pulse appears 5*SAMPLE_DIV clocks after COLLECT entry (no debias).
- Downstream contract: the S-box registers activate_sbox and consumes sbox_in one cycle later. sbox_in must stay stable for at least 2 cycles after the pulse edge. This holds because the minimum word spacing is 5 clocks.
- Health test (on every strobe, using the raw sample before any debiasing):
  - If the sample equals the previous sample, rep_cnt++ (saturating); otherwise rep_cnt <= 1.
  - When rep_cnt reaches REP_LIMIT: health_fail <= 1 and state -> FAIL on that edge. The pending word is discarded and no pulse is issued.
- FAIL:
  - No strobes, no activate_sbox pulses. sbox_in is frozen and busy=0.
  - health_fail stays 1 until enable=0 or reset.
- Simultaneous events:
  - enable falls on a word-completing strobe: IDLE wins, no pulse, sbox_in unchanged.
  - Health trip and word completion on the same strobe: FAIL wins, no pulse.
- Reset mid-word: partial word lost. Collection restarts with WARMUP after enable.

Optional Feature:
- Macro: TRNG_VON_NEUMANN_EN.
- Defined:
  - Strobed samples are paired: 01 -> accept 0, 10 -> accept 1, 00 and 11 -> discard both.
  - A pair register and a pair-phase flag are cleared on IDLE/FAIL.
  - The health test still runs on every strobed sample.
  - Word latency becomes at least 10*SAMPLE_DIV clocks.
- Undefined: every strobed sample is accepted directly. No pair logic is present.

Decomposition:
- Package trng_pkg:
  - State enum IDLE/WARMUP/COLLECT/FAIL.
  - Constants SBOX_W=5, SYNC_STAGES=2, WARMUP_CYCLES=2.
- Sub-module trng_sync2: 2-flop synchroniser with asynchronous active-low reset to 0, instantiated once.

Test Plan:
- Reset and enable behaviour: hold rst_n=0 then release with enable=0 -> all outputs 0, state IDLE, no pulses for 100 cycles.
- Basic word: SAMPLE_DIV=4; raw bit held per sample window as 1,0,1,1,0 -> exactly one activate_sbox pulse 20 clocks after COLLECT entry, with sbox_in=5'b10110, stable for at least 4 following cycles.
- Health trip: REP_LIMIT=16; raw_bit tied to 1 -> no word pulse after the 15th strobe's word boundary. health_fail=1 on the 16th strobe and stays 1. enable low for 1 cycle -> health_fail=0.
- Enable drop mid-word: enable falls after 3 samples, rises later; feed 0,1,1,0,1 -> sbox_in=5'b01101. No contamination from the earlier partial bits.
- Async reset mid-COLLECT: pulse rst_n low for 1 cycle during a strobe -> outputs immediately 0; WARMUP of 2 cycles precedes new sampling.
- TRNG_VON_NEUMANN_EN: sample pairs 01,10,00,11,10,10,01 -> accepted bits 0,1,1,1,0 -> sbox_in=5'b01110 with a single pulse.
